// File: rtl/tdm_demux_pkg.sv
// Shared constants, types and helpers for the 4-channel TDM demultiplexer.
package tdm_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  localparam logic MODE_TDM    = 1'b0;
  localparam logic MODE_DIRECT = 1'b1;

  typedef logic [SLOT_W-1:0] slot_t;

  // NUM_CH is a power of two, so the natural SLOT_W-bit wrap is the modulo.
  function automatic slot_t slot_next(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// Single-entry output holding register for one demux channel.
module demux_ch_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // A full register that is being drained this cycle may be reloaded at once.
  assign free = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= data;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 demultiplexer: slot-counter (TDM) or direct-select routing.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit BLOCKING = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  input  logic                     sel_mode,
  input  logic [1:0]               sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               slot,
  output logic [NUM_CH-1:0]        ovf,
  input  logic                     ovf_clr
);

  slot_t             slot_reg;
  slot_t             tgt;
  logic              accept;
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] ovf_reg;
  logic [NUM_CH-1:0] ovf_next;

  always_comb begin
    tgt = slot_reg;
    if (sel_mode == MODE_DIRECT) begin
      tgt = sel;
    end else if (in_sof) begin
      tgt = '0;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = BLOCKING ? free[tgt] : 1'b1;
    end
  end

  assign accept = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Drops can only occur when non-blocking, since blocking gates in_ready on free.
      assign load[gi] = accept && (tgt == slot_t'(gi)) && free[gi];
      assign drop[gi] = accept && (tgt == slot_t'(gi)) && !free[gi];

      demux_ch_reg #(
        .DATA_W (DATA_W)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[gi]),
        .data      (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[gi*DATA_W +: DATA_W]),
        .free      (free[gi])
      );
    end
  endgenerate

  // A drop in the same cycle as a clear still leaves its flag set.
  assign ovf_next = (ovf_clr ? '0 : ovf_reg) | drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_reg <= '0;
      ovf_reg  <= '0;
    end else begin
      if (accept) begin
        slot_reg <= slot_next(tgt);
      end
      ovf_reg <= ovf_next;
    end
  end

  assign slot = slot_reg;
  assign ovf  = ovf_reg;

endmodule
